// File: rtl/fb_arb.sv
// fb_arb: single-port frame-buffer arbiter between the STN timing detector
// (write side) and the panel refresh engine (read side).
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no RAM operation driven this cycle
// WR    | write access driven this cycle (wr_ack high)
// RD    | read access driven this cycle (rd_ack high)
//
// Read wins contention because refresh is real-time; starve_cnt bounds how
// many read grants a pending write may lose before it is forced through.
// Out-of-range addresses are acknowledged but never reach the RAM.
module fb_arb #(
  parameter int AW          = 13,
  parameter int DW          = 8,
  parameter int DEPTH       = 4800,
  parameter int WR_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          wr_req,
  output logic          wr_ack,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req,
  output logic          rd_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          err_clr,
  output logic          err_oor
);

  localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH);
  localparam logic [3:0]    MAX_WAIT   = 4'(WR_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       wr_elig;
  logic       rd_elig;
  logic       wr_oor;
  logic       rd_oor;
  logic       pipe_v;
  logic       pipe_oor;

  // Arbitration: pick this cycle's grant from eligibility and starvation count.
  always_comb begin
    wr_elig    = wr_req && !wr_ack;
    rd_elig    = rd_req && !rd_ack;
    wr_oor     = (wr_addr >= ADDR_LIMIT);
    rd_oor     = (rd_addr >= ADDR_LIMIT);
    state_nxt  = IDLE;
    starve_nxt = starve_cnt;
    if (wr_elig && rd_elig) begin
      if (starve_cnt < MAX_WAIT) begin
        state_nxt  = RD;
        starve_nxt = starve_cnt + 4'd1;
      end else begin
        state_nxt  = WR;
        starve_nxt = 4'd0;
      end
    end else if (wr_elig) begin
      state_nxt  = WR;
      starve_nxt = 4'd0;
    end else if (rd_elig) begin
      state_nxt = RD;
    end
    if (!wr_req) begin
      starve_nxt = 4'd0;
    end
  end

  // FSM state, registered grant outputs, error flag and read return pipe.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      err_oor    <= 1'b0;
      pipe_v     <= 1'b0;
      pipe_oor   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      wr_ack     <= (state_nxt == WR);
      rd_ack     <= (state_nxt == RD);
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      if (state_nxt == WR && !wr_oor) begin
        ram_cs    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end
      if (state_nxt == RD && !rd_oor) begin
        ram_cs   <= 1'b1;
        ram_addr <= rd_addr;
      end
      // a new violation outranks a clear arriving in the same cycle
      if ((state_nxt == WR && wr_oor) || (state_nxt == RD && rd_oor)) begin
        err_oor <= 1'b1;
      end else if (err_clr) begin
        err_oor <= 1'b0;
      end
      // a read access without chip select was trapped and returns zero
      pipe_v   <= (state == RD);
      pipe_oor <= !ram_cs;
      rd_valid <= pipe_v;
      if (pipe_v) begin
        rd_data <= pipe_oor ? '0 : ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_arb.sv
// tb_fb_arb: directed and randomized checks of fb_arb against a transaction
// level reference (reference memory, read-return queue, grant rules).
module tb_fb_arb;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 4800;
  localparam int MAXW  = 4;

  logic          clk = 1'b0;
  logic          rst_x = 1'b0;
  logic          wr_req, rd_req, err_clr;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_ack, rd_valid, ram_cs, ram_we, err_oor;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  fb_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WR_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_x(rst_x),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .err_clr(err_clr), .err_oor(err_oor)
  );

  // synchronous frame-buffer RAM
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs && ram_addr < AW'(DEPTH)) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  typedef struct { int due; logic [DW-1:0] d; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          m_wr_ack, m_rd_ack, m_cs, m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_starve;
  logic          prev_wr_ack, prev_rd_ack;
  bit            wr_fin, rd_fin;
  int            wr_start, rd_start;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_wr_ack = 0; m_rd_ack = 0; m_cs = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_starve = 0;
    prev_wr_ack = 0; prev_rd_ack = 0;
    rq.delete();
  endtask

  // apply the grant rules to the inputs of the current cycle
  task automatic predict();
    bit we, re, set_err;
    int g;
    we = wr_req && !m_wr_ack;
    re = rd_req && !m_rd_ack;
    g = 0;
    set_err = 0;
    if (we && re) begin
      if (m_starve < MAXW) begin g = 2; m_starve++; end
      else begin g = 1; m_starve = 0; end
    end else if (we) begin
      g = 1; m_starve = 0;
    end else if (re) begin
      g = 2;
    end
    if (!wr_req) m_starve = 0;
    m_wr_ack = (g == 1);
    m_rd_ack = (g == 2);
    m_cs = 0;
    m_we = 0;
    if (g == 1) begin
      if (int'(wr_addr) < DEPTH) begin
        m_cs = 1; m_we = 1; m_addr = wr_addr; m_wdata = wr_data;
        ref_mem[wr_addr] = wr_data;
      end else set_err = 1;
    end
    if (g == 2) begin
      if (int'(rd_addr) < DEPTH) begin
        m_cs = 1; m_addr = rd_addr;
        rq.push_back('{due: cyc + 3, d: ref_mem[rd_addr]});
      end else begin
        set_err = 1;
        rq.push_back('{due: cyc + 3, d: 8'h00});
      end
    end
    if (set_err) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  // advance one cycle and compare every output against the model
  task automatic tick();
    bit ev;
    predict();
    @(posedge clk);
    #1;
    cyc++;
    chk("wr_ack", wr_ack, m_wr_ack);
    chk("rd_ack", rd_ack, m_rd_ack);
    chk("ram_cs", ram_cs, m_cs);
    chk("ram_we", ram_we, m_we);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("err_oor", err_oor, m_err);
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    chk("rd_valid", rd_valid, ev);
    if (ev) begin
      chk("rd_data", rd_data, rq[0].d);
      void'(rq.pop_front());
    end
    chk("wr_ack_twice", prev_wr_ack && wr_ack, 1'b0);
    chk("rd_ack_twice", prev_rd_ack && rd_ack, 1'b0);
    prev_wr_ack = wr_ack;
    prev_rd_ack = rd_ack;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_ack"}, wr_ack, 0);
    chk({tag, "_rd_ack"}, rd_ack, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_ram_cs"}, ram_cs, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_err_oor"}, err_oor, 0);
  endtask

  // random requesters: hold req through the ack cycle, then maybe re-request
  task automatic run_random(input int n, input int pw, input int pr);
    wr_fin = 0;
    rd_fin = 0;
    for (int i = 0; i < n; i++) begin
      if (wr_ack) begin
        chk("wr_wait_bound", (cyc - wr_start) <= 2 * MAXW + 2, 1'b1);
        wr_fin = 1;
      end else if (!wr_req || wr_fin) begin
        wr_fin = 0;
        if (int'($urandom_range(99)) < pw) begin
          wr_req = 1; wr_addr = AW'($urandom_range(DEPTH - 1));
          wr_data = DW'($urandom); wr_start = cyc;
        end else wr_req = 0;
      end
      if (rd_ack) begin
        rd_fin = 1;
      end else if (!rd_req || rd_fin) begin
        rd_fin = 0;
        if (int'($urandom_range(99)) < pr) begin
          rd_req = 1; rd_addr = AW'($urandom_range(DEPTH - 1)); rd_start = cyc;
        end else rd_req = 0;
      end
      err_clr = ($urandom_range(15) == 0);
      tick();
    end
    wr_req = 0;
    rd_req = 0;
    err_clr = 0;
    repeat (5) tick();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = '0;
      ref_mem[a] = '0;
    end
    ram_rdata = '0;
    wr_req = 0; rd_req = 0; err_clr = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_start = 0; rd_start = 0;
    m_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #3 rst_x = 1;
    tick();

    // single write
    wr_req = 1; wr_addr = 13'h0028; wr_data = 8'hA5;
    tick();
    chk("sw_ack", wr_ack, 1);
    chk("sw_cs", ram_cs, 1);
    chk("sw_we", ram_we, 1);
    chk("sw_addr", ram_addr, 16'h0028);
    tick();
    chk("sw_one_ack", wr_ack, 0);
    wr_req = 0;
    tick();

    // single read of the top address
    wr_req = 1; wr_addr = 13'h12BF; wr_data = 8'h3C;
    tick();
    tick();
    wr_req = 0;
    rd_req = 1; rd_addr = 13'h12BF;
    tick();
    chk("sr_ack", rd_ack, 1);
    tick();
    rd_req = 0;
    tick();
    chk("sr_valid", rd_valid, 1);
    chk("sr_data", rd_data, 16'h003C);
    tick();

    // out-of-range write and read, error clear, clear vs new violation
    wr_req = 1; wr_addr = 13'h12C0; wr_data = 8'h55;
    tick();
    chk("oor_wr_ack", wr_ack, 1);
    chk("oor_wr_cs", ram_cs, 0);
    chk("oor_wr_err", err_oor, 1);
    tick();
    wr_req = 0;
    rd_req = 1; rd_addr = 13'h1FFF;
    tick();
    chk("oor_rd_cs", ram_cs, 0);
    tick();
    rd_req = 0;
    tick();
    chk("oor_rd_valid", rd_valid, 1);
    chk("oor_rd_data", rd_data, 0);
    err_clr = 1;
    tick();
    chk("err_clr", err_oor, 0);
    wr_req = 1; wr_addr = 13'h1500;
    tick();
    chk("err_set_wins", err_oor, 1);
    err_clr = 0;
    tick();
    wr_req = 0;
    err_clr = 1;
    tick();
    err_clr = 0;
    tick();

    // reset in the cycle after rd_ack of a read
    rd_req = 1; rd_addr = 13'h0028;
    tick();
    tick();
    rd_req = 0;
    #2 rst_x = 0;
    #1;
    chk_all_zero("midrst");
    m_reset();
    @(posedge clk);
    #3 rst_x = 1;
    repeat (4) tick();

    // random soak, then saturated contention, then read-heavy mix
    run_random(400, 50, 50);
    run_random(200, 100, 100);
    run_random(300, 30, 80);

    for (int a = 0; a < DEPTH; a++) begin
      if (ref_mem[a] !== 8'h00 || mem[a] !== 8'h00) chk("ram_contents", mem[a], ref_mem[a]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
